// File: rtl/uart_prog_loader.sv
// Serial program loader: 8N1 UART receiver feeding a session FSM that parses a
// 16-bit word-count header and writes little-endian 32-bit words to instruction memory.
module uart_prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 180,
  parameter int unsigned ADDR_WIDTH   = 14
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  upg_start,
  input  logic                  rx,
  output logic                  prog_wen,
  output logic [ADDR_WIDTH-1:0] prog_addr,
  output logic [31:0]           prog_data,
  output logic                  upg_busy,
  output logic                  upg_done,
  output logic                  frame_err
);

  localparam int unsigned       CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_HDR0, S_HDR1, S_DATA, S_DONE} s_state_t;

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid, byte_err;

  s_state_t         s_state, s_next;
  logic             start_d;
  logic [15:0]      word_cnt;
  logic [1:0]       byte_idx;
  logic [23:0]      word_buf;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    rx_next = rx_state;
    if (!upg_start) begin
      rx_next = RX_IDLE;
    end else begin
      case (rx_state)
        RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
        RX_START: if (clk_cnt == HALF_M1) rx_next = rx_sync ? RX_IDLE : RX_DATA;
        RX_DATA:  if (clk_cnt == FULL_M1 && bit_idx == 3'd7) rx_next = RX_STOP;
        RX_STOP:  if (clk_cnt == FULL_M1) rx_next = RX_IDLE;
        default:  rx_next = RX_IDLE;
      endcase
    end
  end

  // Bit timer restarts on every state change so sampling stays centred on each bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
      if (rx_next != rx_state || rx_state == RX_IDLE || clk_cnt == FULL_M1)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + 1'b1;
      if (rx_state == RX_START)
        bit_idx <= '0;
      if (upg_start && rx_state == RX_DATA && clk_cnt == FULL_M1) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 1'b1;
      end
      if (upg_start && rx_state == RX_STOP && clk_cnt == FULL_M1) begin
        byte_valid <= rx_sync;
        byte_err   <= !rx_sync;
      end
    end
  end

  always_comb begin
    s_next = s_state;
    if (!upg_start) begin
      s_next = S_IDLE;
    end else begin
      case (s_state)
        S_IDLE: if (!start_d) s_next = S_HDR0;
        S_HDR0: if (byte_valid) s_next = S_HDR1;
        S_HDR1: if (byte_valid) s_next = ({rx_shift, word_cnt[7:0]} == 16'd0) ? S_DONE : S_DATA;
        S_DATA: if (prog_wen && word_cnt == 16'd1) s_next = S_DONE;
        S_DONE: s_next = S_DONE;
        default: s_next = S_IDLE;
      endcase
    end
  end

  // Bytes 0..2 shift into word_buf from the top so the 4th byte completes the word
  // in one load; prog_data therefore only changes when a full word is ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s_state   <= S_IDLE;
      start_d   <= 1'b0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      prog_wen  <= 1'b0;
      prog_addr <= '0;
      prog_data <= '0;
      frame_err <= 1'b0;
    end else begin
      s_state  <= s_next;
      start_d  <= upg_start;
      prog_wen <= upg_start && s_state == S_DATA && byte_valid && byte_idx == 2'd3;
      if (s_state == S_IDLE && s_next == S_HDR0) begin
        prog_addr <= '0;
        byte_idx  <= '0;
        frame_err <= 1'b0;
      end else if (byte_err) begin
        frame_err <= 1'b1;
      end
      if (upg_start && byte_valid) begin
        case (s_state)
          S_HDR0: word_cnt[7:0]  <= rx_shift;
          S_HDR1: word_cnt[15:8] <= rx_shift;
          S_DATA: begin
            byte_idx <= byte_idx + 1'b1;
            if (byte_idx == 2'd3)
              prog_data <= {rx_shift, word_buf};
            else
              word_buf <= {rx_shift, word_buf[23:8]};
          end
          default: ;
        endcase
      end
      if (prog_wen) begin
        prog_addr <= prog_addr + 1'b1;
        word_cnt  <= word_cnt - 1'b1;
      end
    end
  end

  assign upg_busy = (s_state == S_HDR0) || (s_state == S_HDR1) || (s_state == S_DATA);
  assign upg_done = (s_state == S_DONE);

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: two instances (ADDR_WIDTH 14 and 2), 4 clocks per bit.
module tb_uart_prog_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0, rx_a = 1'b1;
  logic        start_b = 1'b0, rx_b = 1'b1;

  logic        wen_a, busy_a, done_a, ferr_a;
  logic [13:0] addr_a;
  logic [31:0] data_a;
  logic        wen_b, busy_b, done_b, ferr_b;
  logic [1:0]  addr_b;
  logic [31:0] data_b;

  uart_prog_loader #(.CLKS_PER_BIT(4), .ADDR_WIDTH(14)) dut_a (
    .clock(clock), .reset(reset), .upg_start(start_a), .rx(rx_a),
    .prog_wen(wen_a), .prog_addr(addr_a), .prog_data(data_a),
    .upg_busy(busy_a), .upg_done(done_a), .frame_err(ferr_a)
  );

  uart_prog_loader #(.CLKS_PER_BIT(4), .ADDR_WIDTH(2)) dut_b (
    .clock(clock), .reset(reset), .upg_start(start_b), .rx(rx_b),
    .prog_wen(wen_b), .prog_addr(addr_b), .prog_data(data_b),
    .upg_busy(busy_b), .upg_done(done_b), .frame_err(ferr_b)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
  int          dbl_a = 0, dbl_b = 0;
  logic        prev_a = 1'b0, prev_b = 1'b0;

  always @(negedge clock) begin
    if (wen_a) begin
      qa_addr.push_back(32'(addr_a));
      qa_data.push_back(data_a);
      if (prev_a) dbl_a++;
    end
    if (wen_b) begin
      qb_addr.push_back(32'(addr_b));
      qb_data.push_back(data_b);
      if (prev_b) dbl_b++;
    end
    prev_a = wen_a;
    prev_b = wen_b;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_rx(sel, fr[i]);
      tick(4);
    end
    set_rx(sel, 1'b1);
  endtask

  logic [7:0] t1_bytes [10] = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  logic [7:0] t3_bytes [4]  = '{8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] t6_bytes [6]  = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
  logic [31:0] wrap_addr [5] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    check_eq("rst_wen",   wen_a,  0);
    check_eq("rst_addr",  addr_a, 0);
    check_eq("rst_data",  data_a, 0);
    check_eq("rst_busy",  busy_a, 0);
    check_eq("rst_done",  done_a, 0);
    check_eq("rst_ferr",  ferr_a, 0);
    reset = 1'b1;
    tick(3);

    // Two words, sent back-to-back with no idle gap between frames
    start_a = 1'b1;
    tick(2);
    check_eq("t1_busy_start", busy_a, 1);
    foreach (t1_bytes[i]) send_byte(0, t1_bytes[i], 1'b1);
    tick(12);
    check_eq("t1_nstrobe", 32'(qa_addr.size()), 2);
    check_eq("t1_addr0", qa_addr[0], 32'd0);
    check_eq("t1_data0", qa_data[0], 32'h12345678);
    check_eq("t1_addr1", qa_addr[1], 32'd1);
    check_eq("t1_data1", qa_data[1], 32'hDEADBEEF);
    check_eq("t1_done", done_a, 1);
    check_eq("t1_busy_end", busy_a, 0);
    check_eq("t1_addr_after", addr_a, 2);
    check_eq("t1_data_hold", data_a, 32'hDEADBEEF);
    start_a = 1'b0;
    tick(2);
    check_eq("t1_done_drop", done_a, 0);
    check_eq("t1_busy_drop", busy_a, 0);

    // Zero-word header
    qa_addr.delete(); qa_data.delete();
    start_a = 1'b1;
    tick(2);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    tick(12);
    check_eq("t2_done", done_a, 1);
    check_eq("t2_nstrobe", 32'(qa_addr.size()), 0);
    start_a = 1'b0;
    tick(2);

    // Framing error on first data byte, then resend
    start_a = 1'b1;
    tick(2);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h44, 1'b0);
    tick(12);
    check_eq("t3_ferr", ferr_a, 1);
    check_eq("t3_nstrobe_err", 32'(qa_addr.size()), 0);
    check_eq("t3_busy_err", busy_a, 1);
    foreach (t3_bytes[i]) send_byte(0, t3_bytes[i], 1'b1);
    tick(12);
    check_eq("t3_nstrobe", 32'(qa_addr.size()), 1);
    check_eq("t3_addr", qa_addr[0], 32'd0);
    check_eq("t3_data", qa_data[0], 32'h11223344);
    check_eq("t3_done", done_a, 1);
    check_eq("t3_ferr_sticky", ferr_a, 1);
    start_a = 1'b0;
    tick(2);

    // Short low glitch while waiting for the header
    qa_addr.delete(); qa_data.delete();
    start_a = 1'b1;
    tick(2);
    check_eq("t4_ferr_cleared", ferr_a, 0);
    rx_a = 1'b0;
    tick(2);
    rx_a = 1'b1;
    tick(20);
    check_eq("t4_ferr", ferr_a, 0);
    check_eq("t4_busy", busy_a, 1);
    check_eq("t4_done", done_a, 0);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    tick(12);
    check_eq("t4_hdr_intact", done_a, 1);
    check_eq("t4_nstrobe", 32'(qa_addr.size()), 0);
    start_a = 1'b0;
    tick(2);

    // Address wrap on the 2-bit instance
    start_b = 1'b1;
    tick(2);
    send_byte(1, 8'h05, 1'b1);
    send_byte(1, 8'h00, 1'b1);
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 4; j++) send_byte(1, 8'((k + 1) * 17), 1'b1);
    tick(12);
    check_eq("t5_nstrobe", 32'(qb_addr.size()), 5);
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("t5_addr%0d", k), qb_addr[k], wrap_addr[k]);
      check_eq($sformatf("t5_data%0d", k), qb_data[k], 32'h11111111 * (k + 1));
    end
    check_eq("t5_done", done_b, 1);
    start_b = 1'b0;
    tick(2);

    // Abort mid-word, then reset mid-frame
    qa_addr.delete(); qa_data.delete();
    start_a = 1'b1;
    tick(2);
    send_byte(0, 8'h03, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'hAA, 1'b1);
    send_byte(0, 8'hBB, 1'b1);
    start_a = 1'b0;
    tick(2);
    check_eq("t6_busy_drop", busy_a, 0);
    check_eq("t6_done_drop", done_a, 0);
    start_a = 1'b1;
    tick(2);
    send_byte(0, 8'h02, 1'b1);
    rx_a = 1'b0;
    tick(6);
    reset = 1'b0;
    #1;
    check_eq("t6_rst_wen",  wen_a,  0);
    check_eq("t6_rst_addr", addr_a, 0);
    check_eq("t6_rst_data", data_a, 0);
    check_eq("t6_rst_busy", busy_a, 0);
    check_eq("t6_rst_done", done_a, 0);
    check_eq("t6_rst_ferr", ferr_a, 0);
    rx_a = 1'b1;
    start_a = 1'b0;
    tick(4);
    check_eq("t6_nstrobe_abort", 32'(qa_addr.size()), 0);
    reset = 1'b1;
    tick(4);
    start_a = 1'b1;
    tick(2);
    foreach (t6_bytes[i]) send_byte(0, t6_bytes[i], 1'b1);
    tick(12);
    check_eq("t6_nstrobe", 32'(qa_addr.size()), 1);
    check_eq("t6_addr", qa_addr[0], 32'd0);
    check_eq("t6_data", qa_data[0], 32'h12345678);
    check_eq("t6_done", done_a, 1);
    start_a = 1'b0;
    tick(2);

    check_eq("wen_width_a", dbl_a, 0);
    check_eq("wen_width_b", dbl_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
